// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one FIFO write port among N_REQ
// valid/ready producers, granting bounded bursts and stalling on full.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_w_en,
    output logic [DATA_W-1:0]          fifo_data_in,
    output logic                       grant_active,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0]  BURST_LAST = CW'(BURST_MAX);
    localparam logic [IDW-1:0] LAST_ID    = IDW'(N_REQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] owner, owner_nx;
    logic [IDW-1:0] rr_ptr, rr_ptr_nx;
    logic [CW-1:0]  beat_cnt, beat_cnt_nx;

    // Unpack the flat data bus into one word per requester.
    logic [DATA_W-1:0] lane_data [N_REQ];
    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign lane_data[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Round-robin pick: first valid index at or after rr_ptr, wrapping.
    logic           pick_found;
    logic [IDW-1:0] pick_id;
    always_comb begin
        logic [IDW:0] cand;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ))
                cand = cand - (IDW+1)'(N_REQ);
            if (!pick_found && req_valid[cand[IDW-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = cand[IDW-1:0];
            end
        end
    end

    // Owner status; the bounds guard only matters for non-power-of-two N_REQ.
    logic           own_valid;
    logic [CW-1:0]  beat_inc;
    logic [IDW-1:0] owner_next_ptr;
    assign own_valid      = (int'(owner) < N_REQ) ? req_valid[owner] : 1'b0;
    assign beat_inc       = beat_cnt + CW'(1);
    assign owner_next_ptr = (owner == LAST_ID) ? '0 : owner + IDW'(1);

    // Next-state and outputs; full only gates outputs, a stall holds state.
    always_comb begin
        state_nx     = state;
        owner_nx     = owner;
        rr_ptr_nx    = rr_ptr;
        beat_cnt_nx  = beat_cnt;
        req_ready    = '0;
        fifo_w_en    = 1'b0;
        fifo_data_in = '0;
        grant_active = 1'b0;
        grant_id     = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_nx    = pick_id;
                    beat_cnt_nx = '0;
                    state_nx    = GRANT;
                end
            end
            GRANT: begin
                grant_active     = 1'b1;
                grant_id         = owner;
                req_ready[owner] = !fifo_full;
                fifo_w_en        = own_valid && !fifo_full;
                fifo_data_in     = lane_data[owner];
                if (!own_valid || (!fifo_full && beat_inc == BURST_LAST)) begin
                    // Owner dropped out or burst exhausted: hand back priority.
                    state_nx    = IDLE;
                    rr_ptr_nx   = owner_next_ptr;
                    beat_cnt_nx = '0;
                end else if (!fifo_full) begin
                    beat_cnt_nx = beat_inc;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, DATA_W=8, BURST_MAX=4).
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_w_en;
    logic [7:0]  fifo_data_in;
    logic        grant_active;
    logic [1:0]  grant_id;

    int total = 0;
    int bad   = 0;
    int wcnt [4];
    int cnt  [4];
    int wsnap;

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(8), .BURST_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_w_en    (fifo_w_en),
        .fifo_data_in (fifo_data_in),
        .grant_active (grant_active),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    // Count accepted FIFO writes per owner, sampled mid-cycle.
    always @(negedge clk)
        if (rst === 1'b1 && fifo_w_en === 1'b1) wcnt[grant_id] = wcnt[grant_id] + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setd(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic out(input string t, input logic ga, input logic [1:0] id,
                       input logic wen, input logic [7:0] d, input logic [3:0] rdy);
        #1;
        chk({t, ".active"}, 32'(grant_active), 32'(ga));
        chk({t, ".id"},     32'(grant_id),     32'(id));
        chk({t, ".w_en"},   32'(fifo_w_en),    32'(wen));
        chk({t, ".data"},   32'(fifo_data_in), 32'(d));
        chk({t, ".ready"},  32'(req_ready),    32'(rdy));
    endtask

    initial begin
        rst = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
        #3;
        out("reset", 0, 0, 0, 8'h00, 4'b0000);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out("idle", 0, 0, 0, 8'h00, 4'b0000);
            tick();
        end

        // Single requester 2: burst of four, bubble, re-grant.
        setd(2, 8'h10); req_valid = 4'b0100;
        out("single.arb", 0, 0, 0, 8'h00, 4'b0000);
        tick();
        for (int b = 0; b < 4; b++) begin
            out("single.b1", 1, 2, 1, 8'(8'h10 + b), 4'b0100);
            tick();
            setd(2, 8'(8'h11 + b));
        end
        out("single.gap", 0, 0, 0, 8'h00, 4'b0000);
        tick();
        for (int b = 0; b < 2; b++) begin
            out("single.b2", 1, 2, 1, 8'(8'h14 + b), 4'b0100);
            tick();
            setd(2, 8'(8'h15 + b));
        end
        req_valid = 4'b0000;
        out("single.drop", 1, 2, 0, 8'h16, 4'b0100);
        tick();
        out("single.idle", 0, 0, 0, 8'h00, 4'b0000);

        // Full contention from a fresh reset: grants 0,1,2,3,0.
        rst = 1'b0;
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            setd(i, 8'(i * 16));
        end
        req_valid = 4'b1111;
        out("cont.bub", 0, 0, 0, 8'h00, 4'b0000);
        tick();
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                out("cont.beat", 1, 2'(g % 4), 1, 8'((g % 4) * 16 + cnt[g % 4]),
                    4'(1 << (g % 4)));
                tick();
                cnt[g % 4]++;
                setd(g % 4, 8'((g % 4) * 16 + cnt[g % 4]));
            end
            if (g < 4) begin
                out("cont.bub", 0, 0, 0, 8'h00, 4'b0000);
                tick();
            end
        end
        req_valid = 4'b0000;
        out("cont.end", 0, 0, 0, 8'h00, 4'b0000);
        tick();

        // Full stall after the second beat of requester 1.
        setd(1, 8'h50); req_valid = 4'b0010;
        out("stall.arb", 0, 0, 0, 8'h00, 4'b0000);
        tick();
        for (int b = 0; b < 2; b++) begin
            out("stall.pre", 1, 1, 1, 8'(8'h50 + b), 4'b0010);
            tick();
            setd(1, 8'(8'h51 + b));
        end
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out("stall.full", 1, 1, 0, 8'h52, 4'b0000);
            tick();
        end
        fifo_full = 1'b0;
        for (int b = 2; b < 4; b++) begin
            out("stall.post", 1, 1, 1, 8'(8'h50 + b), 4'b0010);
            tick();
            setd(1, 8'(8'h51 + b));
        end
        req_valid = 4'b0000;
        out("stall.rel", 0, 0, 0, 8'h00, 4'b0000);
        tick();

        // Early release by requester 3, then requester 0 takes over.
        setd(3, 8'h30); setd(0, 8'h00); req_valid = 4'b1001;
        wsnap = wcnt[3];
        out("early.arb", 0, 0, 0, 8'h00, 4'b0000);
        tick();
        for (int b = 0; b < 2; b++) begin
            out("early.beat", 1, 3, 1, 8'(8'h30 + b), 4'b1000);
            tick();
            setd(3, 8'(8'h31 + b));
        end
        req_valid = 4'b0001;
        out("early.drop", 1, 3, 0, 8'h32, 4'b1000);
        tick();
        out("early.bub", 0, 0, 0, 8'h00, 4'b0000);
        chk("early.words3", 32'(wcnt[3] - wsnap), 32'd2);
        tick();
        for (int b = 0; b < 4; b++) begin
            out("early.own0", 1, 0, 1, 8'(b), 4'b0001);
            tick();
            setd(0, 8'(b + 1));
        end

        // Async reset during beat 3 of requester 2 (rr_ptr is 1 beforehand).
        setd(2, 8'h70); req_valid = 4'b0100;
        out("rmid.arb", 0, 0, 0, 8'h00, 4'b0000);
        tick();
        for (int b = 0; b < 2; b++) begin
            out("rmid.beat", 1, 2, 1, 8'(8'h70 + b), 4'b0100);
            tick();
            setd(2, 8'(8'h71 + b));
        end
        wsnap = wcnt[2];
        out("rmid.b3", 1, 2, 1, 8'h72, 4'b0100);
        rst = 1'b0;
        out("rmid.async", 0, 0, 0, 8'h00, 4'b0000);
        tick();
        chk("rmid.nowrite", 32'(wcnt[2] - wsnap), 32'd0);
        out("rmid.held", 0, 0, 0, 8'h00, 4'b0000);
        setd(0, 8'hE0); setd(3, 8'hE3); req_valid = 4'b1101;
        rst = 1'b1;
        out("rmid.bub", 0, 0, 0, 8'h00, 4'b0000);
        tick();
        out("rmid.from0", 1, 0, 1, 8'hE0, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
